// File: rtl/uart_tx_byte_if.sv
// Byte-level handshake between an ASCII sender (master) and the UART transmitter (slave).
interface uart_tx_byte_if;
    logic       start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8-N-1 UART transmitter with internal baud divider; one byte per accepted start pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP (8-E-1).
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | line high, waiting for start
//   S_START  | start bit (tx=0) for DIV cycles
//   S_DATA   | 8 data bits, LSB first, DIV cycles each
//   S_PARITY | even parity of latched byte (parity build only)
//   S_STOP   | stop bit (tx=1); tx_done pulses on its last edge
module uart_tx_byte #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9_600
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_byte_if.slave  bus
);

    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q,  baud_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       data_q,  data_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^data_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif

            S_STOP: begin
                // busy drops on the same edge as done so the sender can re-arm a cycle later
                if (baud_last) begin
                    baud_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte at DIV=10; follows UART_TX_PARITY_EN like the design.
module tb_uart_tx_byte;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * DIV;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_byte_if bus();

    uart_tx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // levels: MSB is the first level on the line (start .. stop, no parity)
    typedef struct {
        logic [7:0] data;
        logic [9:0] levels;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference frame: index 0 is the first line level after the accept edge.
    function automatic logic [10:0] model_seq(input logic [7:0] d);
        logic [10:0] s;
        int ones;
        s    = '1;
        ones = 0;
        s[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i+1] = ((int'(d) >> i) & 1) != 0;
            ones  += (int'(d) >> i) & 1;
        end
        if (PAR) s[9] = (ones % 2) != 0;
        return s;
    endfunction

    function automatic logic [10:0] table_seq(input vec_t v);
        logic [10:0] s;
        s = '1;
        for (int i = 0; i < 10; i++) s[i] = v.levels[9-i];
        if (PAR) begin
            s[9]  = v.par;
            s[10] = 1'b1;
        end
        return s;
    endfunction

    // Sends d, compares every cycle of the frame; optionally pulses start (inj_d) at cycle inj_k.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] seq, input string tag,
                             input int inj_k, input logic [7:0] inj_d);
        int errs;
        errs        = 0;
        bus.start   = 1'b1;
        bus.tx_data = d;
        step();
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            if (bus.tx !== seq[k / DIV] || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0)
                errs++;
            if (k == inj_k) begin
                bus.start   = 1'b1;
                bus.tx_data = inj_d;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        check({tag, "_frame"}, errs, 0);
        check({tag, "_end"}, {bus.tx, bus.tx_busy, bus.tx_done}, 3'b101);
        step();
        check({tag, "_done_clr"}, {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
    endtask

    // Line decoder and done counter, independent of the stimulus thread.
    logic       dec_en = 1'b0;
    int         fr_err = 0;
    int         done_cnt = 0;
    logic [7:0] dec_q[$];

    initial begin
        int k;
        logic in_frame;
        logic [7:0] sh;
        k = 0;
        in_frame = 1'b0;
        sh = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!dec_en) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (bus.tx === 1'b0) begin
                        in_frame = 1'b1;
                        k = 0;
                        sh = '0;
                    end
                end else begin
                    k++;
                end
                if (in_frame && (k % DIV) == DIV / 2) begin
                    if (k / DIV >= 1 && k / DIV <= 8) sh[k / DIV - 1] = bus.tx;
                    if (k / DIV == NBITS - 1) begin
                        if (bus.tx !== 1'b1) fr_err++;
                        dec_q.push_back(sh);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (bus.tx_done === 1'b1) done_cnt++;

    initial begin
        string msg;
        int    idx;
        int    budget;
        int    errs;
        int    rise[$];
        logic  prev_busy;
        logic [7:0] d;

        vecs[0] = '{8'h41, 10'b0100000101, 1'b0};
        vecs[1] = '{8'h55, 10'b0101010101, 1'b0};
        vecs[2] = '{8'hA5, 10'b0101001011, 1'b0};
        vecs[3] = '{8'h00, 10'b0000000001, 1'b0};
        vecs[4] = '{8'hFF, 10'b0111111111, 1'b0};
        vecs[5] = '{8'h80, 10'b0000000011, 1'b1};
        vecs[6] = '{8'h01, 10'b0100000001, 1'b1};
        vecs[7] = '{8'h43, 10'b0110000101, 1'b1};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;

        // reset and idle line
        for (int i = 0; i < 3; i++) step();
        check("reset_outputs", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) errs++;
        end
        check("idle_no_start", errs, 0);

        // table vectors
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].data, table_seq(vecs[i]), $sformatf("vec%0d_%02h", i, vecs[i].data), -1, 8'h00);

        // start during a frame is ignored; exactly one done
        done_cnt = 0;
        run_frame(8'h41, table_seq(vecs[0]), "ignore_start", 35, 8'h55);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) errs++;
        end
        check("ignore_no_second_frame", errs, 0);
        check("ignore_done_count", done_cnt, 1);

        // reset mid data bit
        bus.start   = 1'b1;
        bus.tx_data = 8'h41;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 47; i++) step();
        done_cnt = 0;
        rst = 1'b1;
        step();
        check("midrst_outputs", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
        rst = 1'b0;
        step();
        check("midrst_after", {bus.tx, bus.tx_busy, bus.tx_done}, 3'b100);
        check("midrst_no_done", done_cnt, 0);
        run_frame(8'hA5, table_seq(vecs[2]), "after_rst_A5", -1, 8'h00);

        // randomized bytes and gaps against the reference model
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            run_frame(d, model_seq(d), $sformatf("rand%0d_%02h", i, d), -1, 8'h00);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        // start held high: frames every FRAME+1 cycles
        prev_busy = bus.tx_busy;
        bus.start   = 1'b1;
        bus.tx_data = 8'h3C;
        for (int i = 0; i < 3 * (FRAME + 1) + 5; i++) begin
            step();
            if (bus.tx_busy === 1'b1 && prev_busy !== 1'b1) rise.push_back(cyc);
            prev_busy = bus.tx_busy;
        end
        bus.start = 1'b0;
        check("held_rise_count", rise.size(), 4);
        if (rise.size() >= 3) begin
            check("held_period_1", rise[1] - rise[0], FRAME + 1);
            check("held_period_2", rise[2] - rise[1], FRAME + 1);
        end
        budget = 0;
        while (bus.tx_busy !== 1'b0 && budget < FRAME + 5) begin
            step();
            budget++;
        end
        check("held_drain_busy", bus.tx_busy, 1'b0);
        step();

        // sender model pacing on !tx_busy with the decoded line
        msg      = "DISTANCE = 012.3 cm\n";
        done_cnt = 0;
        fr_err   = 0;
        dec_q.delete();
        dec_en   = 1'b1;
        idx      = 0;
        budget   = 0;
        while (idx < msg.len() && budget < 5000) begin
            if (bus.tx_busy === 1'b0) begin
                bus.start   = 1'b1;
                bus.tx_data = msg[idx];
                idx++;
            end
            step();
            bus.start = 1'b0;
            budget++;
        end
        check("sender_bytes_sent", idx, 20);
        budget = 0;
        while (bus.tx_busy !== 1'b0 && budget < FRAME + 5) begin
            step();
            budget++;
        end
        step();
        step();
        dec_en = 1'b0;
        check("sender_decoded_count", dec_q.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < dec_q.size()) check($sformatf("sender_byte%0d", i), dec_q[i], msg[i]);
        check("sender_done_count", done_cnt, 20);
        check("sender_stop_bits", fr_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
